div_arbiter: RTL

//  Shares one iterative fixed-point divider (Q(WIDTH-FBITS).FBITS, signed) between NREQ requesters.

---
 rtl/div_arbiter_if.sv | 15 +
 rtl/div_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: request/response and divider-side signals of the shared divider arbiter.
interface div_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 32);
  logic [NREQ-1:0] req_valid, req_ready, resp_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] resp_val, div_a, div_b, div_val;
  logic resp_dbz, resp_ovf, div_start, div_busy, div_done, div_dbz, div_ovf;
  modport slave (
    input req_valid, req_a, req_b, div_busy, div_done, div_dbz, div_ovf, div_val,
    output req_ready, resp_valid, resp_val, resp_dbz, resp_ovf, div_start, div_a, div_b
  );
  modport master (
    output req_valid, req_a, req_b, div_busy, div_done, div_dbz, div_ovf, div_val,
    input req_ready, resp_valid, resp_val, resp_dbz, resp_ovf, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative fixed-point divider among NREQ requesters.
// Optional DIV_ARB_ZERO_BYPASS_EN: a==0 && b!=0 answers 0 without using the divider.
module div_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input logic clk,
  input logic rst,
  div_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, SETTLE = 3'd2, WAIT = 3'd3, RESP = 3'd4;
  if (FBITS >= WIDTH || FBITS < 0) begin : g_bad_fbits
    $error("FBITS must lie in 0..WIDTH-1");
  end
  logic [2:0] state;
  logic [IDW-1:0] rr_ptr, id, gnt_id;
  logic [IDW:0] scan;
  logic found, bypass;
  logic [NREQ-1:0] req_ready, resp_valid;
  logic [WIDTH-1:0] acc_a, acc_b, resp_val, div_a, div_b;
  logic resp_dbz, resp_ovf, div_start;
  // Scan from the far end so the requester closest to rr_ptr is written last and wins.
  always_comb begin
    gnt_id = '0;
    found = 1'b0;
    scan = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      scan = scan >= (IDW+1)'(NREQ) ? scan - (IDW+1)'(NREQ) : scan;
      if (bus.req_valid[scan[IDW-1:0]]) begin
        gnt_id = scan[IDW-1:0];
        found = 1'b1;
      end
    end
  end
  assign acc_a = bus.req_a[gnt_id*WIDTH +: WIDTH];
  assign acc_b = bus.req_b[gnt_id*WIDTH +: WIDTH];
`ifdef DIV_ARB_ZERO_BYPASS_EN
  assign bypass = acc_a == '0 && acc_b != '0;
`else
  assign bypass = 1'b0;
`endif
  assign req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << gnt_id : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      id <= '0;
      resp_valid <= '0;
      resp_val <= '0;
      resp_dbz <= 1'b0;
      resp_ovf <= 1'b0;
      div_start <= 1'b0;
      div_a <= '0;
      div_b <= '0;
    end else begin
      div_start <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: if (found) begin
          id <= gnt_id;
          rr_ptr <= gnt_id == IDW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
          div_a <= acc_a;
          div_b <= acc_b;
          div_start <= !bypass;
          state <= bypass ? RESP : ISSUE;
          if (bypass) begin
            resp_valid <= NREQ'(1) << gnt_id;
            resp_val <= '0;
            resp_dbz <= 1'b0;
            resp_ovf <= 1'b0;
          end
        end
        ISSUE: state <= SETTLE;
        SETTLE: state <= WAIT;
        WAIT: if (bus.div_done && !bus.div_busy) begin
          state <= RESP;
          resp_valid <= NREQ'(1) << id;
          resp_val <= (bus.div_dbz || bus.div_ovf) ? '0 : bus.div_val;
          resp_dbz <= bus.div_dbz;
          resp_ovf <= bus.div_ovf;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_val = resp_val;
  assign bus.resp_dbz = resp_dbz;
  assign bus.resp_ovf = resp_ovf;
  assign bus.div_start = div_start;
  assign bus.div_a = div_a;
  assign bus.div_b = div_b;
endmodule
